// File: rtl/l2_writeback_unit_pkg.sv
// Shared types for the L2 flush/writeback engine: sweep states, burst geometry
// and the cache line container.
package l2_writeback_unit_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    CHECK,
    BURST,
    CLEAR,
    NEXT,
    DONE
  } wb_state_t;

  localparam int unsigned BEATS_PER_LINE = 4;

  typedef logic [255:0] line_t;

endpackage

// File: rtl/l2_writeback_unit_if.sv
// Array-side and memory-side signals of the writeback engine; the engine is the
// master, the L2 arrays plus memory bus form the slave.
interface l2_writeback_unit_if
  import l2_writeback_unit_pkg::*;
#(
  parameter int unsigned s_index = 3,
  parameter int unsigned s_tag   = 24,
  parameter int unsigned s_beat  = 64
);

  logic               arr_read;
  logic [s_index-1:0] arr_index;
  logic               dirty_load;
  logic               dirty_datain;
  logic               valid_in;
  logic               dirty_in;
  logic [s_tag-1:0]   tag_in;
  line_t              line_in;
  logic               mem_write;
  logic [31:0]        mem_address;
  logic [s_beat-1:0]  mem_wdata;
  logic               mem_resp;

  modport master (
    output arr_read, arr_index, dirty_load, dirty_datain,
    output mem_write, mem_address, mem_wdata,
    input  valid_in, dirty_in, tag_in, line_in, mem_resp
  );

  modport slave (
    input  arr_read, arr_index, dirty_load, dirty_datain,
    input  mem_write, mem_address, mem_wdata,
    output valid_in, dirty_in, tag_in, line_in, mem_resp
  );

endinterface

// File: rtl/l2_writeback_unit.sv
// L2 flush engine: walks every set, writes each valid+dirty line to memory as a
// 4-beat burst from a latched copy, then clears that set's dirty bit.
module l2_writeback_unit
  import l2_writeback_unit_pkg::*;
#(
  parameter int unsigned s_index  = 3,
  parameter int unsigned s_offset = 5,
  parameter int unsigned s_tag    = 24,
  parameter int unsigned s_beat   = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  l2_writeback_unit_if.master bus
);

  localparam int unsigned NUM_SETS = 2 ** s_index;

  wb_state_t          r_state;
  wb_state_t          w_next;
  logic [s_index-1:0] r_set;
  logic [1:0]         r_beat;
  line_t              r_line;
  logic [31:0]        r_addr;
  logic               r_busy;
  logic               r_done;
  logic               r_arr_read;
  logic               r_dirty_load;
  logic               r_mem_write;

  logic w_hit;
  logic w_last_beat;
  logic w_last_set;

  assign w_hit       = bus.valid_in & bus.dirty_in;
  assign w_last_beat = bus.mem_resp && (r_beat == 2'(BEATS_PER_LINE - 1));
  assign w_last_set  = (r_set == s_index'(NUM_SETS - 1));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = READ;
      READ:    w_next = WAIT;
      WAIT:    w_next = CHECK;
      CHECK:   w_next = w_hit ? BURST : NEXT;
      BURST:   if (w_last_beat) w_next = CLEAR;
      CLEAR:   w_next = NEXT;
      NEXT:    w_next = w_last_set ? DONE : READ;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with the state
  // they belong to while still coming straight out of flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_set        <= '0;
      r_beat       <= '0;
      r_line       <= '0;
      r_addr       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_arr_read   <= 1'b0;
      r_dirty_load <= 1'b0;
      r_mem_write  <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_busy       <= (w_next != IDLE);
      r_done       <= (w_next == DONE);
      r_arr_read   <= (w_next == READ);
      r_dirty_load <= (w_next == CLEAR);
      r_mem_write  <= (w_next == BURST);
      unique case (r_state)
        IDLE: if (start) r_set <= '0;
        CHECK: begin
          if (w_hit) begin
            r_line <= bus.line_in;
            r_addr <= {bus.tag_in, r_set, {s_offset{1'b0}}};
            r_beat <= '0;
          end
        end
        BURST: if (bus.mem_resp) r_beat <= r_beat + 2'd1;
        NEXT:  if (!w_last_set) r_set <= r_set + s_index'(1);
        default: ;
      endcase
    end
  end

  assign busy             = r_busy;
  assign done             = r_done;
  assign bus.arr_read     = r_arr_read;
  assign bus.arr_index    = r_set;
  assign bus.dirty_load   = r_dirty_load;
  assign bus.dirty_datain = 1'b0;
  assign bus.mem_write    = r_mem_write;
  assign bus.mem_address  = r_addr;
  assign bus.mem_wdata    = r_line[s_beat * r_beat +: s_beat];

endmodule
